// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, RVC length detect and a one-deep output register
// toward decode, reading a halfword-addressed instruction memory.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IMEM_AW  = 10
) (
   input  logic               clk,
   input  logic               resetn,
   output logic               imem_ceb,
   output logic               imem_web,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [31:0]        inst,
   output logic [31:0]        inst_pc,
   output logic               inst_rvc
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        rvc_q, rvc_d;

   logic        blocked;
   logic        rd_rvc;
   logic        issue;
   logic [31:0] issue_pc;
   logic [31:0] redir_pc;
   logic [31:0] next_pc;
   logic        unused_bits;

   assign blocked  = valid_q & ~inst_ready;
   assign rd_rvc   = (imem_rdata[1:0] != 2'b11);
   assign redir_pc = {redirect_pc[31:1], 1'b0};
   assign next_pc  = resp_pc_q + (rd_rvc ? 32'd2 : 32'd4);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      valid_d    = valid_q & ~inst_ready;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      rvc_d      = rvc_q;
      issue      = 1'b0;
      issue_pc   = fetch_pc_q;
      if (redirect_valid) begin
         valid_d    = 1'b0;
         issue      = 1'b1;
         issue_pc   = redir_pc;
         resp_pc_d  = redir_pc;
         fetch_pc_d = redir_pc;
         state_d    = S_WAIT;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (!blocked) begin
                  issue     = 1'b1;
                  issue_pc  = fetch_pc_q;
                  resp_pc_d = fetch_pc_q;
                  state_d   = S_WAIT;
               end
            end
            S_WAIT: begin
               if (!blocked) begin
                  valid_d   = 1'b1;
                  inst_d    = rd_rvc ? {16'h0, imem_rdata[15:0]}
                                     : imem_rdata;
                  inst_pc_d = resp_pc_q;
                  rvc_d     = rd_rvc;
                  // chain the next read off this response's length
                  issue     = 1'b1;
                  issue_pc  = next_pc;
                  resp_pc_d = next_pc;
               end else begin
                  // response dropped; re-read it once decode drains
                  fetch_pc_d = resp_pc_q;
                  state_d    = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         valid_q    <= 1'b0;
         inst_q     <= 32'h0;
         inst_pc_q  <= 32'h0;
         rvc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         valid_q    <= valid_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         rvc_q      <= rvc_d;
      end
   end

   assign imem_ceb  = ~(issue & resetn);
   assign imem_web  = 1'b1;
   assign imem_addr = issue_pc[IMEM_AW:1];

   assign inst_valid = valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_rvc   = rvc_q;

   assign unused_bits = ^{redirect_pc[0], issue_pc[31:IMEM_AW+1],
                          issue_pc[0]};

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed stimulus, stream model and
// per-cycle compare, plus a second instance for the address wrap.
module tb_ifetch_unit;
   localparam int AW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          inst_ready;
   logic          imem_ceb, imem_web;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          inst_valid, inst_rvc;
   logic [31:0]   inst, inst_pc;

   logic          w_ceb, w_web, w_valid, w_rvc;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_rdata, w_inst, w_pc;

   logic [15:0]   hw [1024];
   int            n_chk = 0;
   int            n_fail = 0;

   ifetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
      .clk(clk), .resetn(resetn),
      .imem_ceb(imem_ceb), .imem_web(imem_web),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .inst_rvc(inst_rvc)
   );

   ifetch_unit #(.RESET_PC(32'h7FE), .IMEM_AW(AW)) dut_wrap (
      .clk(clk), .resetn(resetn),
      .imem_ceb(w_ceb), .imem_web(w_web),
      .imem_addr(w_addr), .imem_rdata(w_rdata),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .inst_valid(w_valid), .inst_ready(1'b1),
      .inst(w_inst), .inst_pc(w_pc), .inst_rvc(w_rvc)
   );

   function automatic logic [31:0] line(input logic [AW-1:0] a);
      logic [AW-1:0] b;
      b = a + 1'b1;
      return {hw[b], hw[a]};
   endfunction

   // {rvc, inst} that decode must see for a given byte PC
   function automatic logic [32:0] model(input logic [31:0] pc);
      logic [AW-1:0] a, b;
      a = pc[AW:1];
      b = a + 1'b1;
      if (hw[a][1:0] != 2'b11) return {1'b1, 16'h0, hw[a]};
      return {1'b0, hw[b], hw[a]};
   endfunction

   always @(posedge clk) begin
      imem_rdata <= imem_ceb ? 32'hBAD0_BAD3 : line(imem_addr);
      w_rdata    <= w_ceb ? 32'hBAD0_BAD3 : line(w_addr);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // stream model: every presented instruction must be the next one
   initial begin : compare
      logic        armed, p_clear, p_stall, p_rvc;
      logic [31:0] exp_pc, p_inst, p_pc;
      logic [32:0] m;
      int          idle_run;
      armed = 0; p_clear = 0; p_stall = 0; p_rvc = 0;
      exp_pc = 0; p_inst = 0; p_pc = 0; idle_run = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            chk("rst_ceb", {31'h0, imem_ceb}, 32'd1);
            chk("rst_web", {31'h0, imem_web}, 32'd1);
            armed = 1; exp_pc = 0; p_clear = 1;
            p_stall = 0; idle_run = 0;
         end else if (armed) begin
            if (p_clear)
               chk("clear_valid", {31'h0, inst_valid}, 32'd0);
            if (p_stall) begin
               chk("hold_valid", {31'h0, inst_valid}, 32'd1);
               chk("hold_inst", inst, p_inst);
               chk("hold_pc", inst_pc, p_pc);
               chk("hold_rvc", {31'h0, inst_rvc}, {31'h0, p_rvc});
            end
            if (inst_valid) begin
               m = model(exp_pc);
               chk("stream_pc", inst_pc, exp_pc);
               chk("stream_inst", inst, m[31:0]);
               chk("stream_rvc", {31'h0, inst_rvc}, {31'h0, m[32]});
               if (inst_ready) exp_pc = exp_pc + (m[32] ? 32'd2 : 32'd4);
            end
            if (inst_ready && !inst_valid && !p_clear) idle_run++;
            else idle_run = 0;
            chk("liveness", {31'h0, idle_run < 2}, 32'd1);
            if (redirect_valid) exp_pc = {redirect_pc[31:1], 1'b0};
            p_clear = redirect_valid;
            p_stall = inst_valid & ~inst_ready & ~redirect_valid;
            p_inst = inst; p_pc = inst_pc; p_rvc = inst_rvc;
         end
      end
   end

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin : stim
      logic [47:0] ready_pat;
      resetn = 0; inst_ready = 1; redirect_valid = 0; redirect_pc = 0;
      for (int i = 0; i < 1024; i++) hw[i] = 16'(i * 40503 + 4660);
      hw[0] = 16'h0013; hw[1] = 16'h0000; hw[2] = 16'h4501;
      hw[3] = 16'h0093; hw[4] = 16'h00A0; hw[1023] = 16'h0F17;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1;
      smp();
      chk("c0_addr", {22'h0, imem_addr}, 32'h0);
      chk("c0_ceb", {31'h0, imem_ceb}, 32'd0);
      chk("w_c0_addr", {22'h0, w_addr}, 32'h3FF);
      chk("w_c0_ceb", {31'h0, w_ceb}, 32'd0);
      nx(); smp();
      chk("c1_addr", {22'h0, imem_addr}, 32'h2);
      chk("c1_valid", {31'h0, inst_valid}, 32'd0);
      chk("w_c1_addr", {22'h0, w_addr}, 32'h1);
      nx(); smp();
      chk("c2_valid", {31'h0, inst_valid}, 32'd1);
      chk("c2_pc", inst_pc, 32'h0);
      chk("c2_inst", inst, 32'h0000_0013);
      chk("c2_rvc", {31'h0, inst_rvc}, 32'd0);
      chk("c2_addr", {22'h0, imem_addr}, 32'h3);
      chk("w_c2_valid", {31'h0, w_valid}, 32'd1);
      chk("w_c2_inst", w_inst, 32'h0013_0F17);
      chk("w_c2_pc", w_pc, 32'h7FE);
      chk("w_c2_rvc", {31'h0, w_rvc}, 32'd0);
      chk("w_web", {31'h0, w_web}, 32'd1);
      nx(); smp();
      chk("c3_pc", inst_pc, 32'h4);
      chk("c3_inst", inst, 32'h0000_4501);
      chk("c3_rvc", {31'h0, inst_rvc}, 32'd1);
      nx(); smp();
      chk("c4_pc", inst_pc, 32'h6);
      chk("c4_inst", inst, 32'h00A0_0093);
      chk("c4_rvc", {31'h0, inst_rvc}, 32'd0);
      nx(); nx();
      redirect_valid = 1; redirect_pc = 32'h21;
      smp();
      chk("redir_addr", {22'h0, imem_addr}, 32'h10);
      chk("redir_ceb", {31'h0, imem_ceb}, 32'd0);
      nx(); redirect_valid = 0; smp();
      chk("redir_bubble", {31'h0, inst_valid}, 32'd0);
      nx(); smp();
      chk("redir_valid", {31'h0, inst_valid}, 32'd1);
      chk("redir_pc", inst_pc, 32'h20);
      nx(); nx();
      redirect_valid = 1; redirect_pc = 32'h4;
      nx(); redirect_valid = 0;
      nx(); inst_ready = 0;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("stall_ceb", {31'h0, imem_ceb}, 32'd1);
         chk("stall_pc", inst_pc, 32'h4);
         nx();
      end
      inst_ready = 1; smp();
      chk("release_ceb", {31'h0, imem_ceb}, 32'd0);
      chk("release_addr", {22'h0, imem_addr}, 32'h3);
      nx(); smp();
      chk("release_bubble", {31'h0, inst_valid}, 32'd0);
      nx(); smp();
      chk("release_pc", inst_pc, 32'h6);
      nx(); nx(); nx();
      inst_ready = 0;
      nx();
      redirect_valid = 1; redirect_pc = 32'h40;
      smp();
      chk("blk_valid", {31'h0, inst_valid}, 32'd1);
      nx(); redirect_valid = 0; inst_ready = 1; smp();
      chk("blk_cleared", {31'h0, inst_valid}, 32'd0);
      nx(); smp();
      chk("blk_pc", inst_pc, 32'h40);
      repeat (7) nx();
      resetn = 0; smp();
      chk("mid_rst_valid", {31'h0, inst_valid}, 32'd1);
      chk("mid_rst_ceb", {31'h0, imem_ceb}, 32'd1);
      nx(); resetn = 1; smp();
      chk("post_rst_valid", {31'h0, inst_valid}, 32'd0);
      nx(); nx(); smp();
      chk("post_rst_pc", inst_pc, 32'h0);
      ready_pat = 48'hF3B7_6EDF_9FBD;
      for (int i = 0; i < 48; i++) begin
         nx();
         inst_ready = ready_pat[i];
         redirect_valid = (i == 10) || (i == 30);
         redirect_pc = (i == 10) ? 32'h7FB : 32'h101;
      end
      nx(); inst_ready = 1; redirect_valid = 0;
      repeat (8) nx();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
